// File: rtl/sdp_ram_pkg.sv
// Shared state type, limits and lane-merge helper for masked_sdp_ram.
// Parameter upper bounds live here so the merge helper can be width-generic.
package sdp_ram_pkg;

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   localparam int MAX_READ_LAT = 4;
   localparam int MAX_W        = 256;
   localparam int MAX_LANES    = 32;

   typedef logic [MAX_W-1:0]     word_t;
   typedef logic [MAX_LANES-1:0] lane_mask_t;

   // Lanes whose mask bit is set take new_w, all others keep old_w; callers cast to their own width.
   function automatic word_t lane_merge(input word_t       old_w,
                                        input word_t       new_w,
                                        input lane_mask_t  mask,
                                        input int unsigned lane_w);
      word_t       merged;
      int unsigned lane;
      merged = old_w;
      for (int unsigned b = 0; b < MAX_W; b++) begin
         lane = b / lane_w;
         if (lane < MAX_LANES && mask[lane[4:0]]) merged[b] = new_w[b];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sdp_ram_delay_line.sv
// Reset-to-zero shift register of STAGES words; STAGES=0 degenerates to a wire.
module sdp_ram_delay_line #(
   parameter int DW     = 1,
   parameter int STAGES = 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] i_d,
   output logic [DW-1:0] o_q
);

   if (STAGES == 0) begin : g_wire
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;
      assign o_q = i_d;
   end else begin : g_regs
      logic [DW-1:0] r_pipe [STAGES];

      // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
         end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
         end
      end

      assign o_q = r_pipe[STAGES-1];
   end

endmodule

// File: rtl/masked_sdp_ram.sv
// Simple-dual-port RAM with per-lane write mask, zeroing sweep and READ_LAT read pipeline.
// Define SDP_RAM_RDW_FORWARD_EN for new-data (per-lane) same-address read-during-write.
module masked_sdp_ram
   import sdp_ram_pkg::*;
#(
   parameter  int LANE_W   = 10,
   parameter  int LANES    = 2,
   parameter  int DEPTH    = 1024,
   parameter  int READ_LAT = 2,
   localparam int W        = LANES * LANE_W,
   localparam int ADDR_W   = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LANES-1:0]  wr_mask,
   input  logic [W-1:0]      wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [W-1:0]      rd_data,
   output logic              rd_valid
);

   if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT || W > MAX_W || LANES > MAX_LANES) begin : g_bad_cfg
      $error("masked_sdp_ram: READ_LAT or word geometry out of supported range");
   end

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
   logic              w_busy, w_rd_acc, w_wr_acc;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [W-1:0]      w_mem_data;
   logic [LANES-1:0]  w_mem_mask;

   assign w_busy   = (r_state == S_INIT);
   assign busy     = w_busy;
   assign w_rd_acc = rd_en & ~w_busy;
   assign w_wr_acc = wr_en & ~w_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_INIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = S_READY;
               w_cnt_nxt   = '0;
            end
         end
         S_READY: begin
            if (clear) begin
               w_state_nxt = S_INIT;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   // The sweep owns the write port while busy; user writes are dropped then.
   always_comb begin
      w_mem_we   = w_wr_acc;
      w_mem_addr = wr_addr;
      w_mem_data = wr_data;
      w_mem_mask = wr_mask;
      if (w_busy) begin
         w_mem_we   = 1'b1;
         w_mem_addr = r_cnt;
         w_mem_data = '0;
         w_mem_mask = '1;
      end
   end

   logic [W-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; the sweep provides the zeroing.
   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_mem_addr] <= W'(lane_merge(word_t'(r_mem[w_mem_addr]), word_t'(w_mem_data),
                                            lane_mask_t'(w_mem_mask), LANE_W));
   end

   logic         r_rd_valid0;
   logic [W-1:0] r_rd_data0;
   logic [W-1:0] w_rd_data0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid0 <= 1'b0;
         r_rd_data0  <= '0;
      end else begin
         r_rd_valid0 <= w_rd_acc;
         r_rd_data0  <= w_rd_acc ? r_mem[rd_addr] : '0;
      end
   end

`ifdef SDP_RAM_RDW_FORWARD_EN
   logic             r_fwd_hit;
   logic [LANES-1:0] r_fwd_mask;
   logic [W-1:0]     r_fwd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_hit  <= 1'b0;
         r_fwd_mask <= '0;
         r_fwd_data <= '0;
      end else begin
         r_fwd_hit  <= w_rd_acc & w_wr_acc & (rd_addr == wr_addr);
         r_fwd_mask <= wr_mask;
         r_fwd_data <= wr_data;
      end
   end

   assign w_rd_data0 = r_fwd_hit
                     ? W'(lane_merge(word_t'(r_rd_data0), word_t'(r_fwd_data), lane_mask_t'(r_fwd_mask), LANE_W))
                     : r_rd_data0;
`else
   assign w_rd_data0 = r_rd_data0;
`endif

   logic [W:0] w_pipe_out;

   sdp_ram_delay_line #(
      .DW     (W + 1),
      .STAGES (READ_LAT - 1)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   ({r_rd_valid0, w_rd_data0}),
      .o_q   (w_pipe_out)
   );

   assign rd_valid = w_pipe_out[W];
   assign rd_data  = w_pipe_out[W-1:0];

endmodule

// File: tb/tb_masked_sdp_ram.sv
// Self-checking bench for masked_sdp_ram against an array/queue reference model.
// Honours SDP_RAM_RDW_FORWARD_EN when computing same-address read-during-write results.
module tb_masked_sdp_ram;

   localparam int LANE_W   = 10;
   localparam int LANES    = 2;
   localparam int DEPTH    = 1024;
   localparam int READ_LAT = 3;
   localparam int W        = LANES * LANE_W;
   localparam int ADDR_W   = $clog2(DEPTH);

   typedef struct packed {
      logic         v;
      logic [W-1:0] d;
   } out_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear, wr_en, rd_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [LANES-1:0]  wr_mask;
   logic [W-1:0]      wr_data;
   logic              busy, rd_valid;
   logic [W-1:0]      rd_data;

   int checks = 0;
   int errors = 0;

   masked_sdp_ram #(
      .LANE_W   (LANE_W),
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .busy     (busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_mask  (wr_mask),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   always #5 clk = ~clk;

   // Reference model: plain word array, sweep countdown and a queue of per-cycle read results.
   logic [W-1:0] m_mem [DEPTH];
   out_t         m_q[$];
   int           m_left;
   out_t         m_exp;
   logic         m_busy;

   function automatic logic [W-1:0] model_merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                                input logic [LANES-1:0] m);
      logic [W-1:0] r;
      r = o;
      for (int l = 0; l < LANES; l++)
         if (m[l]) r[l*LANE_W +: LANE_W] = n[l*LANE_W +: LANE_W];
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < READ_LAT; i++) m_q.push_back('0);
      m_left = DEPTH;
      m_exp  = '0;
      m_busy = 1'b1;
   endtask

   task automatic model_edge();
      out_t e;
      bit   ar, aw;
      e  = '0;
      ar = rd_en && (m_left == 0);
      aw = wr_en && (m_left == 0);
      if (ar) begin
         e.v = 1'b1;
         e.d = m_mem[rd_addr];
`ifdef SDP_RAM_RDW_FORWARD_EN
         if (aw && wr_addr == rd_addr) e.d = model_merge(e.d, wr_data, wr_mask);
`endif
      end
      if (m_left != 0) begin
         m_mem[DEPTH - m_left] = '0;
         m_left--;
      end else begin
         if (aw) m_mem[wr_addr] = model_merge(m_mem[wr_addr], wr_data, wr_mask);
         if (clear) m_left = DEPTH;
      end
      m_q.push_back(e);
      if (m_q.size() > READ_LAT) void'(m_q.pop_front());
      m_exp  = m_q[0];
      m_busy = (m_left != 0);
   endtask

   // One clock: inputs are stable across the posedge, outputs are sampled at the following negedge.
   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_mask = '0; wr_data = '0;
   endtask

   task automatic issue_read(input logic [ADDR_W-1:0] a);
      rd_en = 1'b1; rd_addr = a;
      step();
      rd_en = 1'b0;
      repeat (READ_LAT - 1) step();
   endtask

   task automatic test_reset();
      int n;
      idle_inputs();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      repeat (3) step();
      checks++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_values got busy=%b v=%b d=%h want busy=1 v=0 d=0", busy, rd_valid, rd_data);
      end
      rst_n = 1'b1;
      n = 0;
      while (busy === 1'b1 && n <= 2 * DEPTH) begin
         step();
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL reset_sweep_len got %0d cycles want %0d", n, DEPTH);
      end
      issue_read(ADDR_W'(DEPTH - 1));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         errors++;
         $display("FAIL read_last_after_sweep got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
      end
   endtask

   task automatic test_masked_write();
      logic [W-1:0] exp_d;
      exp_d = {10'h3FF, 10'h2AA};
      wr_en = 1'b1; wr_addr = 5; wr_data = {10'h3FF, 10'h155}; wr_mask = 2'b11;
      step();
      wr_data = {10'h000, 10'h2AA}; wr_mask = 2'b01;
      step();
      wr_en = 1'b0;
      issue_read(5);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
         errors++;
         $display("FAIL masked_write got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp_d);
      end
      wr_en = 1'b1; wr_mask = 2'b00; wr_data = '1;
      step();
      wr_en = 1'b0;
      issue_read(5);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
         errors++;
         $display("FAIL mask_zero_noop got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp_d);
      end
   endtask

   task automatic test_bubbles();
      logic hist [20];
      for (int i = 0; i < 20; i++) begin
         rd_en   = (i % 2 == 0);
         rd_addr = ADDR_W'($urandom_range(0, 15));
         hist[i] = rd_en;
         step();
         checks++;
         if (rd_valid !== m_exp.v || rd_data !== m_exp.d || busy !== m_busy) begin
            errors++;
            $display("FAIL bubbles_model[%0d] got v=%b d=%h want v=%b d=%h", i, rd_valid, rd_data, m_exp.v, m_exp.d);
         end
         if (i >= READ_LAT - 1) begin
            checks++;
            if (rd_valid !== hist[i-READ_LAT+1] || (!hist[i-READ_LAT+1] && rd_data !== '0)) begin
               errors++;
               $display("FAIL bubbles_slot[%0d] got v=%b d=%h want v=%b", i, rd_valid, rd_data, hist[i-READ_LAT+1]);
            end
         end
      end
      rd_en = 1'b0;
      repeat (READ_LAT) step();
   endtask

   task automatic test_rdw();
      logic [W-1:0] exp_d;
`ifdef SDP_RAM_RDW_FORWARD_EN
      exp_d = {10'h333, 10'h222};
`else
      exp_d = {10'h111, 10'h222};
`endif
      wr_en = 1'b1; wr_addr = 7; wr_data = {10'h111, 10'h222}; wr_mask = 2'b11;
      step();
      wr_data = {10'h333, 10'h444}; wr_mask = 2'b10;
      rd_en = 1'b1; rd_addr = 7;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      repeat (READ_LAT - 1) step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
         errors++;
         $display("FAIL rdw_same_addr got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp_d);
      end
      issue_read(7);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== {10'h333, 10'h222}) begin
         errors++;
         $display("FAIL rdw_after got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {10'h333, 10'h222});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = ADDR_W'($urandom_range(0, 15));
         wr_mask = LANES'($urandom);
         wr_data = W'($urandom);
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ADDR_W'($urandom_range(0, 15));
         step();
         checks++;
         if (rd_valid !== m_exp.v || rd_data !== m_exp.d || busy !== m_busy) begin
            errors++;
            $display("FAIL random[%0d] got v=%b d=%h busy=%b want v=%b d=%h busy=%b",
                     i, rd_valid, rd_data, busy, m_exp.v, m_exp.d, m_busy);
         end
      end
      idle_inputs();
      repeat (READ_LAT) step();
   endtask

   task automatic test_clear();
      logic [W-1:0] pre;
      int obs;
      pre = {10'h155, 10'h0AA};
      wr_en = 1'b1; wr_addr = 5; wr_data = pre; wr_mask = 2'b11;
      step();
      wr_en = 1'b0;
      clear = 1'b1; rd_en = 1'b1; rd_addr = 5;
      step();
      clear = 1'b0; rd_en = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_busy_rise got busy=%b want 1", busy);
      end
      obs = (busy === 1'b1) ? 1 : 0;
      repeat (READ_LAT - 1) begin
         step();
         if (busy === 1'b1) obs++;
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== pre) begin
         errors++;
         $display("FAIL clear_read_old got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, pre);
      end
      for (int k = 0; k < 2 * DEPTH && busy === 1'b1; k++) begin
         clear   = (k == 400);
         wr_en   = (obs >= DEPTH - 4);
         wr_addr = '0; wr_data = '1; wr_mask = '1;
         rd_en   = wr_en; rd_addr = '0;
         step();
         checks++;
         if (rd_valid !== m_exp.v || rd_data !== m_exp.d || busy !== m_busy) begin
            errors++;
            $display("FAIL clear_sweep[%0d] got v=%b d=%h busy=%b want v=%b d=%h busy=%b",
                     k, rd_valid, rd_data, busy, m_exp.v, m_exp.d, m_busy);
         end
         if (busy === 1'b1) obs++;
      end
      idle_inputs();
      checks++;
      if (obs != DEPTH) begin
         errors++;
         $display("FAIL clear_sweep_len got %0d cycles want %0d", obs, DEPTH);
      end
      issue_read(5);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         errors++;
         $display("FAIL clear_addr5_zero got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
      end
      issue_read(0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         errors++;
         $display("FAIL busy_write_ignored got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
      end
   endtask

   task automatic reset_pulse_and_count(input string tag);
      int n;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_async got v=%b d=%h busy=%b want v=0 d=0 busy=1", tag, rd_valid, rd_data, busy);
      end
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      n = 0;
      while (busy === 1'b1 && n <= 2 * DEPTH) begin
         step();
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL %s_sweep_len got %0d cycles want %0d", tag, n, DEPTH);
      end
   endtask

   task automatic test_reset_mid();
      rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rd_addr = ADDR_W'(k);
         step();
      end
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== m_exp.d) begin
         errors++;
         $display("FAIL pipe_before_reset got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, m_exp.d);
      end
      reset_pulse_and_count("rst_pipe");
      wr_en = 1'b1; wr_addr = 700; wr_data = '1; wr_mask = '1;
      step();
      wr_en = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (300) step();
      reset_pulse_and_count("rst_sweep");
      issue_read(700);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         errors++;
         $display("FAIL rst_sweep_addr700 got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_masked_write();
      test_bubbles();
      test_rdw();
      test_random();
      test_clear();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/masked_sdp_ram.md
# masked_sdp_ram

Parametrised simple-dual-port RAM with per-lane write masking, gated-zero reads, a configurable read pipeline with a valid flag, and a self-clearing sweep after reset or on request. It generalises the team's fixed 40b×512 and 20b×1024 masked M20K wrappers to arbitrary lane width, lane count, depth and read latency. It is the storage primitive for the next generation of the buffering and accumulation stages.

## Interface
- LANE_W, 10, bits per maskable lane
- LANES, 2, lane count; word width W = LANES*LANE_W
- DEPTH, 1024, words; ADDR_W = $clog2(DEPTH)
- READ_LAT, 2, read latency in cycles, legal range 1..4
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  pulse; requests a zeroing sweep of the whole array
- busy  out  1  sweep in progress; wr/rd requests ignored
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_mask  in  LANES  bit i enables lane i (bits [i*LANE_W +: LANE_W])
- wr_data  in  W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  W  read data; all-zero when the slot was not a read
- rd_valid  out  1  marks rd_data as the result of an accepted read

## Operation
- FSM states: S_INIT, S_READY.
- Reset puts the FSM in S_INIT with sweep counter = 0.
- S_INIT: each cycle writes zero to all lanes at the counter address, then increments the counter. The cycle that writes DEPTH-1 goes to S_READY.
- busy = (state == S_INIT).
- S_READY: clear=1 goes to S_INIT with counter = 0 on the next edge. A read or write accepted in that same cycle completes normally.
- clear while busy is ignored; the sweep is not restarted.
- A write is accepted when wr_en & !busy. It updates only the lanes with wr_mask=1, and other lanes keep their contents.
- wr_mask = 0 with wr_en = 1 is a legal no-op.
- A read is accepted when rd_en & !busy. It samples the array on the acceptance edge.
- A non-accepted slot enters the pipeline as data = 0, valid = 0.
- Simultaneous read and write to the same address (default): the read returns the old contents.
- Reads to different addresses in the same cycle are unaffected by the write.
- rst_n low mid-sweep or mid-pipeline:
  - all pipeline stages go to 0 and rd_valid to 0;
  - the sweep restarts from address 0 after release.
- The array itself is never cleared by reset logic, only by the sweep.

## Timing
- Reset values: busy=1, rd_valid=0, rd_data=0, state=S_INIT, counter=0.
- After rst_n deasserts, busy stays 1 for exactly DEPTH cycles.
- The first edge after release writes address 0.
- busy=0 from cycle DEPTH onward.
- clear sampled at edge t gives busy=1 from t+1 for DEPTH cycles.
- Read accepted at edge t: rd_data/rd_valid are valid after edge t+READ_LAT-1, i.e. READ_LAT cycles of latency measured request-to-output register.
- The pipeline is free-running with no stall; one read per cycle is sustained.
- A write at edge t is visible to a read accepted at edge t+1.

## Configuration
- SDP_RAM_RDW_FORWARD_EN defined: a same-address read-during-write returns the new data for masked lanes and the old data for unmasked lanes. It uses a one-cycle forwarding register and a per-lane merge.
- SDP_RAM_RDW_FORWARD_EN undefined: read-old behaviour as above. No forwarding logic is instantiated.
- Sweep writes never forward; reads are blocked while busy.

## Structure
- Package sdp_ram_pkg holds:
  - the state enum (S_INIT, S_READY);
  - the constant MAX_READ_LAT = 4;
  - a lane-merge function (old, new, mask) used by the write path and the forwarding path.
- Sub-module sdp_ram_delay_line carries {valid, data} through READ_LAT-1 reset-to-zero register stages. With READ_LAT=1 it is pure wire-through.
- The array is inferred as one W×DEPTH memory with per-lane write enables.

## Test plan
- Reset, release, DEPTH=1024 -> busy high exactly 1024 cycles. Then a read of addr 1023 returns 0 with rd_valid.
- Write 0x3FF_155 mask 2'b11 to addr 5, then mask 2'b01 data 0x000_2AA -> read addr 5 returns 0x3FF_2AA after READ_LAT cycles.
- rd_en=0 in alternate cycles with READ_LAT=3 -> rd_data=0 and rd_valid=0 exactly in the matching output cycles, with no bubbles otherwise.
- Same-cycle write and read of addr 7 (old 0x111_222, new 0x333_444, mask 2'b10):
  - without the macro, the read returns 0x111_222;
  - with the macro, it returns 0x333_222.
- clear pulsed in the same cycle as a read of addr 5 -> the read returns pre-clear data, busy rises next cycle, and after the sweep addr 5 reads 0.
- rst_n pulsed low mid-sweep at counter 300 with reads in flight -> rd_valid drops immediately and the sweep restarts at 0, busy for a full DEPTH cycles.
